div_ctrl: RTL and testbench

Multi-cycle divide sequencer for the EX stage. When the ALU decoder selects `DIV_CONTROL` or `DIVU_CONTROL`, it takes the two operands and runs a 32-iteration restoring division. It stalls the pipeline while the division runs and returns {remainder, quotient} for the HI/LO write. The exception flush (`annul`) aborts an operation in flight.

---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/div_step.sv | 29 ++
 rtl/div_ctrl.sv | 132 +++++++++++++
 tb/tb_div_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared encodings for the EX-stage divide sequencer: ALU control codes, FSM states,
// iteration count and the launch-decode helper.
package div_ctrl_pkg;

    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [4:0] DIV_CONTROL  = 5'b10110;
    localparam logic [4:0] DIVU_CONTROL = 5'b10111;

    typedef enum logic [1:0] {
        StDivFree = 2'd0,
        StDivOn   = 2'd1,
        StDivEnd  = 2'd2
    } div_state_e;

    function automatic logic is_div(input logic [4:0] ctrl);
        return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {rem, quo} left by one, then
// subtract the divisor from the remainder if that does not borrow.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] part;
    logic [WIDTH:0] diff;

    // rem < divisor always holds, so the shifted partial remainder fits in WIDTH+1 bits.
    always_comb begin
        part = {rem_i, quo_i[WIDTH-1]};
        diff = part - {1'b0, divisor_i};
        if (diff[WIDTH]) begin
            rem_o = part[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end else begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer; stalls the pipeline and returns
// {remainder, quotient}. Optional macro DIV_ZERO_FAST_EN short-circuits divide by zero.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_ITER
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [4:0]         alucontrol_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               stall_o
);

    div_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0]       rem_q;
    logic [WIDTH-1:0]       quo_q;
    logic [WIDTH-1:0]       dvs_q;
    logic                   sign_a_q;
    logic                   sign_b_q;
    logic                   signed_q;
    logic [2*WIDTH-1:0]     result_q;
    logic                   ready_q;

    logic                   go;
    logic                   is_signed;
    logic [WIDTH-1:0]       a_abs;
    logic [WIDTH-1:0]       b_abs;
    logic [WIDTH-1:0]       step_rem;
    logic [WIDTH-1:0]       step_quo;
    logic [WIDTH-1:0]       fix_rem;
    logic [WIDTH-1:0]       fix_quo;
`ifdef DIV_ZERO_FAST_EN
    logic [WIDTH-1:0]       zero_quo;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .quo_i    (quo_q),
        .divisor_i(dvs_q),
        .rem_o    (step_rem),
        .quo_o    (step_quo)
    );

    always_comb begin
        is_signed = (alucontrol_i == DIV_CONTROL);
        go        = is_div(alucontrol_i) & ~annul_i;
        a_abs     = (is_signed && a_i[WIDTH-1]) ? -a_i : a_i;
        b_abs     = (is_signed && b_i[WIDTH-1]) ? -b_i : b_i;
        fix_quo   = (signed_q && (sign_a_q ^ sign_b_q)) ? -step_quo : step_quo;
        fix_rem   = (signed_q && sign_a_q) ? -step_rem : step_rem;
`ifdef DIV_ZERO_FAST_EN
        zero_quo  = (is_signed && a_i[WIDTH-1]) ? WIDTH'(1) : {WIDTH{1'b1}};
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StDivFree;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            signed_q <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
        end else if (annul_i) begin
            state_q <= StDivFree;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            unique case (state_q)
                StDivFree: begin
                    ready_q <= 1'b0;
                    if (go) begin
                        rem_q    <= '0;
                        quo_q    <= a_abs;
                        dvs_q    <= b_abs;
                        sign_a_q <= is_signed & a_i[WIDTH-1];
                        sign_b_q <= is_signed & b_i[WIDTH-1];
                        signed_q <= is_signed;
                        cnt_q    <= '0;
`ifdef DIV_ZERO_FAST_EN
                        if (b_i == '0) begin
                            state_q  <= StDivEnd;
                            ready_q  <= 1'b1;
                            result_q <= {a_i, zero_quo};
                        end else begin
                            state_q <= StDivOn;
                        end
`else
                        state_q <= StDivOn;
`endif
                    end
                end
                StDivOn: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    cnt_q <= cnt_q + 1'b1;
                    // Last step: sign fix-up is folded into the output register load.
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q  <= StDivEnd;
                        ready_q  <= 1'b1;
                        result_q <= {fix_rem, fix_quo};
                    end
                end
                StDivEnd: begin
                    ready_q <= 1'b0;
                    state_q <= StDivFree;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= StDivFree;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q & ~annul_i;
    assign stall_o  = (((state_q == StDivFree) & go) | (state_q == StDivOn)) & ~annul_i;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: directed divisions push expected results and ready
// cycles; an independent monitor pops and compares on every ready pulse.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int unsigned W   = 32;
    localparam logic [4:0]  NOP = 5'b00000;
`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
        string          name;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic [4:0]     alucontrol_i = NOP;
    logic [W-1:0]   a_i = '0;
    logic [W-1:0]   b_i = '0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;
    logic           stall_o;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   ready_cnt = 0;
    exp_t exp_q[$];

    div_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alucontrol_i(alucontrol_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .stall_o     (stall_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [2*W-1:0] got,
                         input logic [2*W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (!rst_i && ready_o) begin
            ready_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready cyc=%0d result=%h", cyc, result_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_result"}, result_o, e.res);
                check({e.name, "_ready_cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic launch(input logic [4:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, output int t0);
        @(posedge clk_i);
        #1;
        alucontrol_i = ctrl;
        a_i = a;
        b_i = b;
        t0 = cyc;
        #1;
        check("launch_stall", 64'(stall_o), 64'd1);
    endtask

    // Launch, check stall every cycle up to the ready cycle, confirm the result was seen.
    task automatic run_op(input string name, input logic [4:0] ctrl, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat);
        int   t0;
        exp_t e;
        launch(ctrl, a, b, t0);
        e.res = exp;
        e.cyc = t0 + lat;
        e.name = name;
        exp_q.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk_i);
            #1;
            if (k == 1) begin
                alucontrol_i = NOP;
                a_i = 32'hDEAD_BEEF;
                b_i = 32'h1234_5678;
            end
            #1;
            if (k < lat) begin
                if (stall_o !== 1'b1) check({name, "_stall_busy"}, 64'(stall_o), 64'd1);
            end else begin
                check({name, "_stall_end"}, 64'(stall_o), 64'd0);
            end
        end
        @(negedge clk_i);
        #1;
        check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
    endtask

    initial begin
        int t0;
        int rc;

        repeat (2) @(posedge clk_i);
        #1;
        check("reset_result", result_o, '0);
        check("reset_ready", 64'(ready_o), 64'd0);
        check("reset_stall", 64'(stall_o), 64'd0);
        rst_i = 1'b0;

        run_op("divu_100_7", DIVU_CONTROL, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        run_op("div_m7_2", DIV_CONTROL, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op("div_7_m2", DIV_CONTROL, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        run_op("div_ovf", DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 33);
        run_op("divu_big", DIVU_CONTROL, 32'hFFFF_FFFF, 32'h10,
               {32'hF, 32'h0FFF_FFFF}, 33);
        run_op("divu_5_0", DIVU_CONTROL, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT);
        run_op("div_m5_0", DIV_CONTROL, 32'hFFFF_FFFB, 32'd0,
               {32'hFFFF_FFFB, 32'd1}, ZLAT);
        run_op("div_5_0", DIV_CONTROL, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, ZLAT);

        // Back-to-back: second launch lands in DIV_FREE one cycle after the first ready.
        run_op("b2b_divu_9_3", DIVU_CONTROL, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
        run_op("b2b_div_m9_3", DIV_CONTROL, 32'hFFFF_FFF7, 32'd3,
               {32'd0, 32'hFFFF_FFFD}, 33);

        // Non-divide code is ignored.
        idle(2);
        rc = ready_cnt;
        #1;
        alucontrol_i = NOP;
        a_i = 32'd50;
        b_i = 32'd5;
        #1;
        check("nop_stall", 64'(stall_o), 64'd0);
        idle(40);
        #1;
        check("nop_no_ready", 64'(ready_cnt), 64'(rc));

        // Annul at cycle 10 of an operation.
        rc = ready_cnt;
        launch(DIVU_CONTROL, 32'd100, 32'd7, t0);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk_i);
            #1;
            alucontrol_i = NOP;
        end
        annul_i = 1'b1;
        #1;
        check("annul_stall", 64'(stall_o), 64'd0);
        check("annul_ready", 64'(ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        annul_i = 1'b0;
        #1;
        check("annul_after_stall", 64'(stall_o), 64'd0);
        idle(40);
        #1;
        check("annul_no_ready", 64'(ready_cnt), 64'(rc));
        run_op("post_annul", DIVU_CONTROL, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Reset at cycle 20 of an operation.
        rc = ready_cnt;
        launch(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, t0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_i);
            #1;
            alucontrol_i = NOP;
        end
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        check("rst_result", result_o, '0);
        check("rst_ready", 64'(ready_o), 64'd0);
        check("rst_stall", 64'(stall_o), 64'd0);
        idle(40);
        #1;
        check("rst_no_ready", 64'(ready_cnt), 64'(rc));

        run_op("post_rst", DIVU_CONTROL, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
